fetch_queue: RTL and testbench

Parametrised instruction-fetch stage with a decoupling queue between instruction memory and decode. Each cycle it reads the word at the current program counter and pushes it into a DEPTH-entry FIFO while space exists. Decode pops through a valid/ready handshake, so it can stall without losing fetched instructions. A taken branch redirects the PC and flushes the queue. The block sits between the top-level instructions memory (combinational read, driven through ports) and decode.

---
 rtl/fetch_queue.sv | 107 ++++++++++
 tb/tb_fetch_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch stage with a small decoupling queue in front of decode.
// Every cycle the word at the program counter is fetched and pushed when the
// queue has room (or when the head is being popped in the same cycle). Decode
// drains the queue through out_valid/out_ready. A taken branch reloads the
// PC and flushes the queue; the entry contents are left in place because the
// pointers alone decide what is visible.
module fetch_queue #(
  parameter int XLEN      = 64,
  parameter int ADDR_BITS = 11,
  parameter int DEPTH     = 4,
  parameter int PC_STEP   = 1,
  parameter int RESET_PC  = 0
) (
  input  logic                       clock,
  input  logic                       reset_pc,
  input  logic                       branch,
  input  logic [XLEN-1:0]            pc_target,
  output logic [ADDR_BITS-1:0]       imem_address,
  input  logic [31:0]                imem_read_data,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [31:0]                instruction,
  output logic [XLEN-1:0]            pc_current_instruction,
  output logic [XLEN-1:0]            pc_next_instruction,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [XLEN-1:0]  PC_INC   = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0]  PC_RESET = XLEN'(RESET_PC);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [XLEN-1:0]  program_counter;
  logic [XLEN-1:0]  pc_plus_step;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;

  logic [31:0]      entry_instr   [DEPTH];
  logic [XLEN-1:0]  entry_pc      [DEPTH];
  logic [XLEN-1:0]  entry_pc_next [DEPTH];

  logic pop;
  logic push;

  assign pc_plus_step = program_counter + PC_INC;
  assign imem_address = program_counter[ADDR_BITS-1:0];

  // A full queue can still take a new word when the head leaves this cycle.
  assign pop  = out_valid & out_ready;
  assign push = (count_q < CNT_FULL) | pop;

  assign out_valid              = (count_q != '0);
  assign count                  = count_q;
  assign instruction            = entry_instr[rd_ptr];
  assign pc_current_instruction = entry_pc[rd_ptr];
  assign pc_next_instruction    = entry_pc_next[rd_ptr];

  // PC, pointers and occupancy: reset beats branch beats normal push/pop.
  always_ff @(posedge clock) begin
    if (reset_pc) begin
      program_counter <= PC_RESET;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count_q         <= '0;
    end else if (branch) begin
      // Flush; any pop offered this cycle is dropped along with the queue.
      program_counter <= pc_target;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count_q         <= '0;
    end else begin
      if (push) begin
        program_counter <= pc_plus_step;
        wr_ptr          <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage: cleared only by reset so the head reads zero afterwards.
  always_ff @(posedge clock) begin
    if (reset_pc) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_instr[i]   <= '0;
        entry_pc[i]      <= '0;
        entry_pc_next[i] <= '0;
      end
    end else if (!branch && push) begin
      entry_instr[wr_ptr]   <= imem_read_data;
      entry_pc[wr_ptr]      <= program_counter;
      entry_pc_next[wr_ptr] <= pc_plus_step;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with DEPTH=4, XLEN=64, ADDR_BITS=11.
// Memory model: the word at address a is 0x1000_0000 + a.
module tb_fetch_queue;

  logic         clock = 1'b0;
  logic         reset_pc;
  logic         branch;
  logic [63:0]  pc_target;
  logic [10:0]  imem_address;
  logic [31:0]  imem_read_data;
  logic         out_ready;
  logic         out_valid;
  logic [31:0]  instruction;
  logic [63:0]  pc_current_instruction;
  logic [63:0]  pc_next_instruction;
  logic [2:0]   count;

  int checks = 0;
  int errors = 0;

  fetch_queue #(
    .XLEN(64), .ADDR_BITS(11), .DEPTH(4), .PC_STEP(1), .RESET_PC(0)
  ) dut (
    .clock                  (clock),
    .reset_pc               (reset_pc),
    .branch                 (branch),
    .pc_target              (pc_target),
    .imem_address           (imem_address),
    .imem_read_data         (imem_read_data),
    .out_ready              (out_ready),
    .out_valid              (out_valid),
    .instruction            (instruction),
    .pc_current_instruction (pc_current_instruction),
    .pc_next_instruction    (pc_next_instruction),
    .count                  (count)
  );

  always #5 clock = ~clock;

  assign imem_read_data = 32'h1000_0000 + 32'(imem_address);

  typedef struct {
    logic        rst;
    logic        br;
    logic [63:0] tgt;
    logic        rdy;
    logic        e_valid;
    logic [2:0]  e_count;
    logic [10:0] e_addr;
    logic        chk_head;
    logic [31:0] e_instr;
    logic [63:0] e_pc;
    logic [63:0] e_pc_next;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rst, input logic br, input logic [63:0] tgt,
                              input logic rdy, input logic v, input logic [2:0] c,
                              input logic [10:0] a, input logic ch, input logic [31:0] ins,
                              input logic [63:0] pc, input logic [63:0] pcn);
    vec_t r;
    r.rst = rst; r.br = br; r.tgt = tgt; r.rdy = rdy;
    r.e_valid = v; r.e_count = c; r.e_addr = a; r.chk_head = ch;
    r.e_instr = ins; r.e_pc = pc; r.e_pc_next = pcn;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int cycles;

    reset_pc  = 1'b1;
    branch    = 1'b0;
    pc_target = '0;
    out_ready = 1'b0;

    // rst br tgt rdy | valid count addr chk instr pc pc_next
    // reset, free run
    vq.push_back(mk(1,0,0,0,     0,0,11'h000, 1,32'h0,0,0));
    vq.push_back(mk(1,0,0,0,     0,0,11'h000, 1,32'h0,0,0));
    vq.push_back(mk(0,0,0,1,     1,1,11'h001, 1,32'h1000_0000,0,1));
    vq.push_back(mk(0,0,0,1,     1,1,11'h002, 1,32'h1000_0001,1,2));
    vq.push_back(mk(0,0,0,1,     1,1,11'h003, 1,32'h1000_0002,2,3));
    // reset mid-stream, stall fill to full, then simultaneous push/pop drain
    vq.push_back(mk(1,0,0,1,     0,0,11'h000, 1,32'h0,0,0));
    vq.push_back(mk(0,0,0,0,     1,1,11'h001, 1,32'h1000_0000,0,1));
    vq.push_back(mk(0,0,0,0,     1,2,11'h002, 1,32'h1000_0000,0,1));
    vq.push_back(mk(0,0,0,0,     1,3,11'h003, 1,32'h1000_0000,0,1));
    vq.push_back(mk(0,0,0,0,     1,4,11'h004, 1,32'h1000_0000,0,1));
    vq.push_back(mk(0,0,0,0,     1,4,11'h004, 1,32'h1000_0000,0,1));
    vq.push_back(mk(0,0,0,0,     1,4,11'h004, 1,32'h1000_0000,0,1));
    vq.push_back(mk(0,0,0,1,     1,4,11'h005, 1,32'h1000_0001,1,2));
    vq.push_back(mk(0,0,0,1,     1,4,11'h006, 1,32'h1000_0002,2,3));
    vq.push_back(mk(0,0,0,1,     1,4,11'h007, 1,32'h1000_0003,3,4));
    vq.push_back(mk(0,0,0,1,     1,4,11'h008, 1,32'h1000_0004,4,5));
    vq.push_back(mk(0,0,0,1,     1,4,11'h009, 1,32'h1000_0005,5,6));
    // reset while full, fill 3, branch to 0x40 with a pop offered
    vq.push_back(mk(1,0,0,0,     0,0,11'h000, 1,32'h0,0,0));
    vq.push_back(mk(0,0,0,0,     1,1,11'h001, 1,32'h1000_0000,0,1));
    vq.push_back(mk(0,0,0,0,     1,2,11'h002, 1,32'h1000_0000,0,1));
    vq.push_back(mk(0,0,0,0,     1,3,11'h003, 1,32'h1000_0000,0,1));
    vq.push_back(mk(0,1,64'h40,1, 0,0,11'h040, 1,32'h1000_0000,0,1));
    vq.push_back(mk(0,0,0,1,     1,1,11'h041, 1,32'h1000_0040,64'h40,64'h41));
    vq.push_back(mk(0,0,0,1,     1,1,11'h042, 1,32'h1000_0041,64'h41,64'h42));
    // branch and reset on the same edge
    vq.push_back(mk(1,1,64'h123,1, 0,0,11'h000, 1,32'h0,0,0));
    vq.push_back(mk(0,0,0,1,     1,1,11'h001, 1,32'h1000_0000,0,1));
    // address wrap at 0x7FF, PC keeps counting past it
    vq.push_back(mk(0,1,64'h7FF,1, 0,0,11'h7FF, 0,32'h0,0,0));
    vq.push_back(mk(0,0,0,1,     1,1,11'h000, 1,32'h1000_07FF,64'h7FF,64'h800));
    vq.push_back(mk(0,0,0,1,     1,1,11'h001, 1,32'h1000_0000,64'h800,64'h801));
    // back-to-back branches, only the last target is fetched
    vq.push_back(mk(0,1,64'h100,1, 0,0,11'h100, 0,32'h0,0,0));
    vq.push_back(mk(0,1,64'h200,1, 0,0,11'h200, 0,32'h0,0,0));
    vq.push_back(mk(0,0,0,1,     1,1,11'h201, 1,32'h1000_0200,64'h200,64'h201));

    foreach (vq[i]) begin
      reset_pc  = vq[i].rst;
      branch    = vq[i].br;
      pc_target = vq[i].tgt;
      out_ready = vq[i].rdy;
      step();
      check($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vq[i].e_valid));
      check($sformatf("v%0d count", i), 64'(count), 64'(vq[i].e_count));
      check($sformatf("v%0d imem_address", i), 64'(imem_address), 64'(vq[i].e_addr));
      if (vq[i].chk_head) begin
        check($sformatf("v%0d instruction", i), 64'(instruction), 64'(vq[i].e_instr));
        check($sformatf("v%0d pc_current", i), pc_current_instruction, vq[i].e_pc);
        check($sformatf("v%0d pc_next", i), pc_next_instruction, vq[i].e_pc_next);
      end
    end

    // Steady-state throughput: one instruction per cycle at count=1.
    reset_pc = 1'b1; branch = 1'b0; out_ready = 1'b1;
    step();
    step();
    reset_pc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("run%0d pc", i), pc_current_instruction, 64'(i));
      check($sformatf("run%0d instr", i), 64'(instruction), 64'(32'h1000_0000 + i));
      check($sformatf("run%0d count", i), 64'(count), 64'd1);
    end

    // Stall from empty: full after exactly DEPTH edges, PC frozen, clean drain.
    reset_pc = 1'b1; out_ready = 1'b0;
    step();
    reset_pc = 1'b0;
    cycles = 0;
    while (count != 3'd4 && cycles < 20) begin
      step();
      cycles++;
    end
    check("fill_cycles", 64'(cycles), 64'd4);
    step();
    step();
    check("stall_addr", 64'(imem_address), 64'h4);
    check("stall_count", 64'(count), 64'd4);
    check("drain_head0", pc_current_instruction, 64'd0);
    out_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      check($sformatf("drain%0d pc", i), pc_current_instruction, 64'(i));
      check($sformatf("drain%0d count", i), 64'(count), 64'd4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
